// File: rtl/load_data_extender.sv
// -----------------------------------------------------------------------------
// load_data_extender
//
// Registered load-data alignment and extension stage for the load path.
// Selects a byte / halfword / word / (64-bit builds) doubleword field from a
// raw, naturally aligned memory read beat, sign- or zero-extends it to the
// full data width, flags misaligned or illegal accesses, and decouples the
// memory side from writeback with a two-entry valid/ready skid buffer.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   in_valid_i     upstream beat valid
//   in_ready_o     block can accept a beat (registered, no path from out_ready_i)
//   in_data_i      raw memory read word
//   in_offset_i    byte offset of the access within in_data_i
//   in_size_i      0 byte, 1 half, 2 word, 3 dword
//   in_unsigned_i  1 = zero-extend, 0 = sign-extend
//   in_tag_i       sideband tag, passed through unchanged
//   out_valid_o    result valid
//   out_ready_i    downstream accepts the result
//   out_data_o     extended result (0 on error)
//   out_err_o      access misaligned or size illegal for DATA_W
//   out_tag_o      tag of the result
// -----------------------------------------------------------------------------
module load_data_extender #(
  parameter int  DATA_W = 32,
  parameter int  TAG_W  = 5,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [OFF_W-1:0]  in_offset_i,
  input  logic [1:0]        in_size_i,
  input  logic              in_unsigned_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_err_o,
  output logic [TAG_W-1:0]  out_tag_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic [TAG_W-1:0]  tag;
  } beat_t;

  beat_t oreg, sreg, in_beat;
  logic  oreg_valid, sreg_valid;

  // ---------------------------------------------------------------------------
  // Combinational alignment and extension of the incoming beat
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shifted;     // field moved down to bit 0
  logic [DATA_W-1:0] hi_mask;     // ones above the field
  logic [6:0]        field_bits;  // 8, 16, 32 or 64
  logic [OFF_W-1:0]  size_mask;   // low offset bits that must be zero
  logic              field_msb;
  logic              sign_fill;
  logic              misaligned;
  logic              illegal;

  always_comb begin
    // NOTE: every signal assigned in this block gets a value on every path,
    // so no latches are inferred.
    shifted    = in_data_i >> {in_offset_i, 3'b000};
    field_bits = 7'd8 << in_size_i;
    // A shift by the full width (dword on 64-bit) leaves the mask all-zero.
    hi_mask    = {DATA_W{1'b1}} << field_bits;
    size_mask  = OFF_W'((4'd1 << in_size_i) - 4'd1);
    misaligned = (in_offset_i & size_mask) != '0;
    illegal    = (in_size_i == 2'd3) && (DATA_W == 32);

    field_msb = shifted[7];
    case (in_size_i)
      2'd0: field_msb = shifted[7];
      2'd1: field_msb = shifted[15];
      2'd2: field_msb = shifted[31];
      2'd3: field_msb = shifted[DATA_W-1];
      default: field_msb = shifted[7];
    endcase
    sign_fill = !in_unsigned_i && field_msb;

    in_beat.tag = in_tag_i;
    in_beat.err = misaligned || illegal;
    if (in_beat.err) begin
      in_beat.data = '0;
    end else if (sign_fill) begin
      in_beat.data = shifted | hi_mask;
    end else begin
      in_beat.data = shifted & ~hi_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: OREG drives the outputs, SREG absorbs one beat under stall
  // ---------------------------------------------------------------------------
  logic in_fire;
  logic oreg_free;

  assign in_ready_o = !sreg_valid;
  assign in_fire    = in_valid_i && in_ready_o;
  assign oreg_free  = !oreg_valid || out_ready_i;

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      // NOTE: the payload registers are cleared too, not just the valids,
      // because the outputs must read as zero straight after reset.
      oreg       <= '0;
      sreg       <= '0;
      oreg_valid <= 1'b0;
      sreg_valid <= 1'b0;
    end else if (oreg_free) begin
      if (sreg_valid) begin
        // in_ready_o was low, so no input beat can arrive on this edge.
        oreg       <= sreg;
        oreg_valid <= 1'b1;
        sreg_valid <= 1'b0;
      end else if (in_fire) begin
        oreg       <= in_beat;
        oreg_valid <= 1'b1;
      end else begin
        oreg_valid <= 1'b0;
      end
    end else if (in_fire) begin
      sreg       <= in_beat;
      sreg_valid <= 1'b1;
    end
  end

  assign out_valid_o = oreg_valid;
  assign out_data_o  = oreg.data;
  assign out_err_o   = oreg.err;
  assign out_tag_o   = oreg.tag;

endmodule

// File: tb/tb_load_data_extender.sv
// -----------------------------------------------------------------------------
// tb_load_data_extender
//
// Drives a 32-bit and a 64-bit instance of load_data_extender with identical
// handshakes and the same raw beat (the 32-bit build sees the low word and the
// low offset bits). A reference model treats the block as a two-entry FIFO of
// extended results and checks both instances after every clock edge.
// -----------------------------------------------------------------------------
module tb_load_data_extender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [2:0]  in_offset = '0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_data32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_data64;
  logic [4:0]  out_tag64;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = !clk;

  load_data_extender #(.DATA_W(32), .TAG_W(5)) dut32 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .in_data_i(in_data[31:0]), .in_offset_i(in_offset[1:0]),
    .in_size_i(in_size), .in_unsigned_i(in_unsigned), .in_tag_i(in_tag),
    .out_valid_o(out_valid32), .out_ready_i(out_ready),
    .out_data_o(out_data32), .out_err_o(out_err32), .out_tag_o(out_tag32)
  );

  load_data_extender #(.DATA_W(64), .TAG_W(5)) dut64 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .in_data_i(in_data), .in_offset_i(in_offset),
    .in_size_i(in_size), .in_unsigned_i(in_unsigned), .in_tag_i(in_tag),
    .out_valid_o(out_valid64), .out_ready_i(out_ready),
    .out_data_o(out_data64), .out_err_o(out_err64), .out_tag_o(out_tag64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick S bytes at the byte offset, extend, or flag an error.
  function automatic void model(input int w, input logic [63:0] data, input int off,
                                input int size, input bit uns,
                                output logic [63:0] res, output bit err);
    int          s;
    logic [63:0] mask, field;
    s   = 1 << size;
    err = (off % s != 0) || (size == 3 && w == 32);
    res = '0;
    if (err) return;
    mask  = (s == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * s)) - 64'd1);
    field = (data >> (8 * off)) & mask;
    if (!uns && field[8 * s - 1]) field = field | ~mask;
    if (w == 32) field = field & 64'h0000_0000_FFFF_FFFF;
    res = field;
  endfunction

  typedef struct {
    logic [63:0] d32;
    bit          e32;
    logic [63:0] d64;
    bit          e64;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  bit   started   = 1'b0;
  bit   after_rst = 1'b0;

  // Scoreboard: update the FIFO model on each edge, then compare just after it.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      started   = 1'b1;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (out_valid32 && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready32) begin
        model(32, {32'h0, in_data[31:0]}, int'(in_offset[1:0]), int'(in_size),
              in_unsigned, e.d32, e.e32);
        model(64, in_data, int'(in_offset), int'(in_size), in_unsigned, e.d64, e.e64);
        e.tag = in_tag;
        q.push_back(e);
      end
    end
    #1;
    if (started) begin
      check("valid32", 64'(out_valid32), 64'(q.size() > 0));
      check("valid64", 64'(out_valid64), 64'(q.size() > 0));
      check("ready32", 64'(in_ready32), 64'(q.size() < 2));
      check("ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        check("data32", 64'(out_data32), q[0].d32);
        check("err32",  64'(out_err32),  64'(q[0].e32));
        check("tag32",  64'(out_tag32),  64'(q[0].tag));
        check("data64", out_data64,      q[0].d64);
        check("err64",  64'(out_err64),  64'(q[0].e64));
        check("tag64",  64'(out_tag64),  64'(q[0].tag));
      end
      if (after_rst) begin
        check("rst_data32", 64'(out_data32), 64'h0);
        check("rst_err32",  64'(out_err32),  64'h0);
        check("rst_tag32",  64'(out_tag32),  64'h0);
        check("rst_data64", out_data64,      64'h0);
        check("rst_tag64",  64'(out_tag64),  64'h0);
      end
    end
  end

  // Downstream ready pattern: 0 always ready, 1 random, 2 stall window, 3 held off.
  int ready_mode = 0;
  int cyc        = 0;
  int stall_lo   = 0;
  int stall_hi   = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [63:0] data, input logic [2:0] off, input logic [1:0] size,
                      input logic uns, input logic [4:0] tag);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = data; in_offset = off;
    in_size = size; in_unsigned = uns; in_tag = tag;
    while (!in_ready32 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_random();
    logic [63:0] d;
    logic [2:0]  off;
    logic [1:0]  size;
    d    = {$urandom(), $urandom()};
    size = 2'($urandom_range(0, 3));
    off  = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) off = off & ~3'((4'd1 << size) - 4'd1);
    send(d, off, size, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    logic [63:0] r;
    bit          e;

    // Hand-computed pins on the model itself.
    model(32, 64'h80FF7F01, 3, 0, 0, r, e); check("pin_lb",   r, 64'hFFFF_FF80);
    model(32, 64'h80FF7F01, 3, 0, 1, r, e); check("pin_lbu",  r, 64'h0000_0080);
    model(32, 64'h80FF7F01, 1, 0, 0, r, e); check("pin_lb1",  r, 64'h0000_007F);
    model(32, 64'h80011234, 2, 1, 0, r, e); check("pin_lh",   r, 64'hFFFF_8001);
    model(32, 64'h80011234, 1, 1, 0, r, e); check("pin_mis",  64'(e), 64'h1);
    check("pin_mis_d", r, 64'h0);
    model(32, 64'h80011234, 0, 3, 0, r, e); check("pin_ill",  64'(e), 64'h1);
    model(64, 64'h8000_0000_0000_0001, 0, 3, 0, r, e);
    check("pin_ld", r, 64'h8000_0000_0000_0001);
    model(64, 64'h8000_0000_1234_5678, 4, 2, 0, r, e);
    check("pin_lw64", r, 64'hFFFF_FFFF_8000_0000);

    // Reset.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Directed test-plan beats.
    send(64'h80FF7F01, 3'd3, 2'd0, 1'b0, 5'd1);
    send(64'h80FF7F01, 3'd3, 2'd0, 1'b1, 5'd2);
    send(64'h80FF7F01, 3'd1, 2'd0, 1'b0, 5'd3);
    send(64'h80011234, 3'd2, 2'd1, 1'b0, 5'd4);
    send(64'h80011234, 3'd1, 2'd1, 1'b0, 5'd5);
    send(64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b0, 5'd6);
    send(64'h8000_0000_1234_5678, 3'd4, 2'd2, 1'b0, 5'd7);
    send(64'h8000_0000_1234_5678, 3'd4, 2'd2, 1'b1, 5'd8);
    idle(3);

    // Backpressure: tags 1..6 back-to-back, downstream stalled in cycles 2-5.
    stall_lo   = cyc + 2;
    stall_hi   = cyc + 6;
    ready_mode = 2;
    for (int t = 1; t <= 6; t++) send({$urandom(), $urandom()}, 3'd0, 2'd2, 1'b0, 5'(t));
    idle(8);

    // Full throughput.
    ready_mode = 0;
    for (int i = 0; i < 100; i++) send_random();
    idle(3);

    // Random handshakes on both sides.
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      send_random();
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    ready_mode = 0;
    idle(4);

    // Reset mid-operation with OREG and SREG full and a beat on the input.
    ready_mode = 3;
    send(64'h0000_00F0, 3'd0, 2'd0, 1'b0, 5'd9);
    send(64'h0000_F000, 3'd0, 2'd1, 1'b1, 5'd10);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_tag = 5'd11;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    ready_mode = 0;
    send(64'h0000_0080, 3'd0, 2'd0, 1'b0, 5'd12);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_data_extender.md
# load_data_extender

Registered load-data alignment and extension stage for the riscv-jedro-1 load path. It selects a byte, halfword, word or (64-bit builds) doubleword field from a raw memory read beat using the address byte offset. It sign- or zero-extends the field to the full data width, flags misaligned and illegal accesses, and decouples the memory side from the writeback side with a valid/ready skid buffer. It supersedes purely combinational fixed-width sign extension on the load path.

## Interface

Parameters:
- DATA_W, 32, data path width in bits; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried with each load (destination register index).
- OFF_W, derived = log2(DATA_W/8), width of the byte offset; not user-overridable.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- in_valid_i  input  1  upstream beat valid.
- in_ready_o  output  1  block can accept a beat this cycle.
- in_data_i  input  DATA_W  raw memory read word, naturally aligned to DATA_W.
- in_offset_i  input  OFF_W  byte offset of the access within in_data_i.
- in_size_i  input  2  0 byte, 1 half, 2 word, 3 dword.
- in_unsigned_i  input  1  1 = zero-extend (LBU/LHU/LWU), 0 = sign-extend.
- in_tag_i  input  TAG_W  sideband, passed through unchanged.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- out_data_o  output  DATA_W  extended result.
- out_err_o  output  1  access misaligned or size illegal for DATA_W.
- out_tag_o  output  TAG_W  tag of the result.

## Operation

Transfers:
- Input transfer: in_valid_i && in_ready_o at a rising edge.
- Output transfer: out_valid_o && out_ready_i at a rising edge.

Field extraction:
- size bytes S = 1 << in_size_i.
- field = in_data_i[8*offset +: 8*S].
- Result = field extended to DATA_W: replicate field MSB if in_unsigned_i=0, else zeros.
- When S*8 == DATA_W, in_unsigned_i has no effect.

Errors (result data forced to 0, out_err_o=1, tag still passed):
- Misaligned: in_offset_i mod S != 0.
- Illegal: in_size_i=3 with DATA_W=32.

Storage:
- Output register (OREG) plus one skid register (SREG), each holding {data, err, tag, valid}.
- Extension is computed combinationally from input fields before registering; both registers hold already-extended results.
- in_ready_o = !SREG.valid (pure register output, no combinational path from out_ready_i).

Per clock edge:
- If OREG empty or output transfer occurs: OREG loads SREG if SREG valid (SREG clears), else loads the input beat if an input transfer occurs, else OREG becomes empty.
- If OREG full and no output transfer: an input transfer loads SREG.
- If SREG drains into OREG and an input transfer occurs the same edge: impossible by construction, because in_ready_o was 0.
- Ordering is strictly FIFO; no beat is dropped or duplicated.

Reset:
- A rising edge with rst_i=1 clears OREG.valid and SREG.valid and zeroes all stored data/err/tag.
- Input transfers presented in that cycle are discarded.
- Reset mid-stream discards both held results.

## Timing

- Reset values, after the first edge with rst_i=1: out_valid_o=0, out_data_o=0, out_err_o=0, out_tag_o=0, in_ready_o=1.
- Latency: 1 cycle. A beat accepted at edge n appears on out_* after edge n, provided OREG was empty or draining.
- Throughput: 1 beat/cycle sustained while out_ready_i=1.
- Backpressure: with out_ready_i=0 and OREG full, one further beat is absorbed into SREG; in_ready_o then drops to 0 the cycle after that acceptance.
- in_ready_o returns to 1 the cycle after SREG drains.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_data_o, out_err_o and out_tag_o hold constant.
- out_valid_o never deasserts without an output transfer, except on reset.

## Test plan

- Sign/zero byte, DATA_W=32: data 0x80FF7F01, offset 3, size 0, unsigned 0 -> 0xFFFFFF80 next cycle. Same with unsigned 1 -> 0x00000080. Offset 1, unsigned 0 -> 0x0000007F.
- Halfword and misalign: data 0x8001_1234, offset 2, size 1, signed -> 0xFFFF8001, err 0. Offset 1, size 1 -> data 0, err 1, tag preserved.
- Illegal size, DATA_W=32: size 3 -> err 1, data 0. DATA_W=64 build: data 0x8000_0000_0000_0001, offset 0, size 3 -> same value, err 0. Size 2, offset 4, data 0x8000_0000_xxxx_xxxx signed -> 0xFFFF_FFFF_8000_0000.
- Backpressure: stream tags 1..6 back-to-back with out_ready_i=0 for cycles 2-5 -> in_ready_o low exactly while SREG is full, outputs stable while stalled, tags emerge 1..6 in order with none lost.
- Full throughput: 100 random beats with in_valid_i and out_ready_i held at 1 -> one result per cycle and in_ready_o never 0; every result matches the reference model.
- Reset mid-operation: OREG and SREG full, rst_i=1 for one edge -> out_valid_o=0, in_ready_o=1, outputs zero. Next accepted beat appears with 1-cycle latency.
